// File: rtl/alu_bist.sv
// ---------------------------------------------------------------------------
// alu_bist -- built-in self-test initiator for the 64-bit ALU.
//
// Drives pseudo-random operand pairs (two free-running Galois LFSRs) through
// every supported ALU opcode, compresses each response into a 64-bit MISR
// and compares the final signature against GOLDEN_SIG.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   begin a run; only looked at in IDLE or DONE
//   a, b         out  registered ALU operands
//   alu_control  out  registered ALU opcode
//   ALUresult    in   ALU result (combinational from a/b/alu_control)
//   zero         in   ALU zero flag
//   busy         out  run in progress; datapath mux select
//   done         out  run complete; level, held until next start or reset
//   pass         out  valid while done=1; signature matched GOLDEN_SIG
//   signature    out  current MISR value
//
// Handshake: start is a level sampled on the rising edge while the engine
// is IDLE or DONE; it is ignored while busy=1. busy and done are mutually
// exclusive levels; pass is meaningful only while done=1. The ALU consumer
// must gate on busy, because a/b/alu_control keep their last values in
// IDLE and DONE.
//
// Each vector takes two cycles: DRIVE loads the operands, SAMPLE folds the
// ALU response (computed from the operands held since the previous edge)
// into the MISR. The FSM state is held in state_q.
// ---------------------------------------------------------------------------
module alu_bist #(
  parameter int          WIDTH        = 64,
  parameter int          NUM_PATTERNS = 16,
  parameter logic [63:0] SEED_A       = 64'h0000_0000_0000_0001,
  parameter logic [63:0] SEED_B       = 64'h0000_0000_0000_0002,
  parameter logic [63:0] GOLDEN_SIG   = 64'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] ALUresult,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Feedback taps shared by both LFSRs and the MISR.
  localparam logic [63:0] POLY = 64'h1B;

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [63:0] SEED_A_EFF = (SEED_A == 64'h0) ? 64'h1 : SEED_A;
  localparam logic [63:0] SEED_B_EFF = (SEED_B == 64'h0) ? 64'h1 : SEED_B;

  localparam logic [15:0] LAST_PAT = 16'(NUM_PATTERNS - 1);
  localparam logic [3:0]  LAST_OP  = 4'd9;

  function automatic logic [63:0] lfsr_step(input logic [63:0] q);
    lfsr_step = {q[62:0], 1'b0} ^ (q[63] ? POLY : 64'h0);
  endfunction

  function automatic logic [3:0] opcode(input logic [3:0] idx);
    case (idx)
      4'd0:    opcode = 4'b0000; // AND
      4'd1:    opcode = 4'b0001; // OR
      4'd2:    opcode = 4'b0010; // ADD
      4'd3:    opcode = 4'b0110; // SUB
      4'd4:    opcode = 4'b0111; // SLT
      4'd5:    opcode = 4'b1000; // XOR
      4'd6:    opcode = 4'b1001; // SLL
      4'd7:    opcode = 4'b1010; // SRL
      4'd8:    opcode = 4'b1011; // SRA
      4'd9:    opcode = 4'b1100; // SLTU
      default: opcode = 4'b0000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  op_idx_q, op_idx_d;
  logic [15:0] pat_cnt_q, pat_cnt_d;
  logic [63:0] lfsr_a_q, lfsr_a_d;
  logic [63:0] lfsr_b_q, lfsr_b_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [63:0] sig_q, sig_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [63:0] sig_next;
  logic [63:0] lfsr_a_next;
  logic [63:0] lfsr_b_next;
  logic        last_vec;

  assign sig_next = {sig_q[62:0], 1'b0} ^ (sig_q[63] ? POLY : 64'h0)
                  ^ ALUresult ^ {63'b0, zero};
  assign lfsr_a_next = lfsr_step(lfsr_a_q);
  assign lfsr_b_next = lfsr_step(lfsr_b_q);
  assign last_vec    = (op_idx_q == LAST_OP) && (pat_cnt_q == LAST_PAT);

  always_comb begin
    state_d   = state_q;
    op_idx_d  = op_idx_q;
    pat_cnt_d = pat_cnt_q;
    lfsr_a_d  = lfsr_a_q;
    lfsr_b_d  = lfsr_b_q;
    a_d       = a_q;
    b_d       = b_q;
    ctl_d     = ctl_q;
    sig_d     = sig_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // The first vector is the seed pair itself.
          lfsr_a_d  = SEED_A_EFF;
          lfsr_b_d  = SEED_B_EFF;
          a_d       = SEED_A_EFF;
          b_d       = SEED_B_EFF;
          op_idx_d  = 4'd0;
          pat_cnt_d = 16'd0;
          ctl_d     = opcode(4'd0);
          sig_d     = 64'h0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          state_d   = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        sig_d = sig_next;
        if (last_vec) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (sig_next == GOLDEN_SIG);
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
        end
      end

      S_DRIVE: begin
        // LFSRs run continuously across opcodes; no reseed at the wrap.
        lfsr_a_d = lfsr_a_next;
        lfsr_b_d = lfsr_b_next;
        a_d      = lfsr_a_next;
        b_d      = lfsr_b_next;
        if (pat_cnt_q == LAST_PAT) begin
          pat_cnt_d = 16'd0;
          op_idx_d  = op_idx_q + 4'd1;
        end else begin
          pat_cnt_d = pat_cnt_q + 16'd1;
        end
        ctl_d   = opcode(op_idx_d);
        state_d = S_SAMPLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_idx_q  <= 4'd0;
      pat_cnt_q <= 16'd0;
      lfsr_a_q  <= SEED_A_EFF;
      lfsr_b_q  <= SEED_B_EFF;
      a_q       <= 64'h0;
      b_q       <= 64'h0;
      ctl_q     <= 4'd0;
      sig_q     <= 64'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_idx_q  <= op_idx_d;
      pat_cnt_q <= pat_cnt_d;
      lfsr_a_q  <= lfsr_a_d;
      lfsr_b_q  <= lfsr_b_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctl_q     <= ctl_d;
      sig_q     <= sig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign alu_control = ctl_q;
  assign signature   = sig_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_alu_bist.sv
// ---------------------------------------------------------------------------
// tb_alu_bist -- directed bench for alu_bist.
//
// dut1: NUM_PATTERNS=1, seeds 1/2, GOLDEN_SIG hand-computed below.
//   Opcode k sees a=2^k, b=2^(k+1). Responses:
//   AND 0 (zero=1), OR 6, ADD 12, SUB -8, SLT 1, XOR 0x60, SLL 0x40,
//   SRL 0x80, SRA 0x100, SLTU 1 (shift amount is b[5:0], always 0 here).
//   MISR chain: 1, 4, 4, ..FFF0, ..FFFA, ..FF8F, ..FF45, ..FE11, ..FD39,
//   final 64'hFFFF_FFFF_FFFF_FA68.
// dut2: NUM_PATTERNS=16, SEED_A=0 (behaves as 1), SEED_B=2, GOLDEN_SIG=0.
// ---------------------------------------------------------------------------
module tb_alu_bist;

  localparam logic [63:0] GOLD1  = 64'hFFFF_FFFF_FFFF_FA68;
  localparam logic [3:0]  OP_SUB = 4'b0110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [3:0] op_f(input int idx);
    case (idx)
      0: op_f = 4'b0000;
      1: op_f = 4'b0001;
      2: op_f = 4'b0010;
      3: op_f = 4'b0110;
      4: op_f = 4'b0111;
      5: op_f = 4'b1000;
      6: op_f = 4'b1001;
      7: op_f = 4'b1010;
      8: op_f = 4'b1011;
      9: op_f = 4'b1100;
      default: op_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [63:0] alu_f(input logic [63:0] x, input logic [63:0] y,
                                        input logic [3:0] c);
    case (c)
      4'b0000: alu_f = x & y;
      4'b0001: alu_f = x | y;
      4'b0010: alu_f = x + y;
      4'b0110: alu_f = x - y;
      4'b0111: alu_f = {63'b0, $signed(x) < $signed(y)};
      4'b1000: alu_f = x ^ y;
      4'b1001: alu_f = x << y[5:0];
      4'b1010: alu_f = x >> y[5:0];
      4'b1011: alu_f = $signed(x) >>> y[5:0];
      4'b1100: alu_f = {63'b0, x < y};
      default: alu_f = 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] lfsr_f(input logic [63:0] q);
    lfsr_f = {q[62:0], 1'b0} ^ (q[63] ? 64'h1B : 64'h0);
  endfunction

  function automatic logic [63:0] misr_f(input logic [63:0] s, input logic [63:0] r);
    misr_f = {s[62:0], 1'b0} ^ (s[63] ? 64'h1B : 64'h0) ^ r ^ {63'b0, (r == 64'h0)};
  endfunction

  // ---------------- dut1 and its ALU model ----------------
  logic        rst1, st1, z1, busy1, done1, pass1;
  logic [63:0] a1, b1, r1, sig1;
  logic [3:0]  c1;
  bit          inj1 = 1'b0;

  // Fault mode flips result bit 5 for SUB. The only SUB vector here
  // (8-16 = ..FFF8) already has bit 5 set, so a stuck-at-1 would be silent.
  always_comb begin
    r1 = alu_f(a1, b1, c1);
    if (inj1 && c1 == OP_SUB) r1[5] = ~r1[5];
  end
  assign z1 = (r1 == 64'h0);

  alu_bist #(.WIDTH(64), .NUM_PATTERNS(1), .SEED_A(64'h1), .SEED_B(64'h2),
             .GOLDEN_SIG(GOLD1)) dut1 (
    .clk(clk), .reset(rst1), .start(st1), .a(a1), .b(b1), .alu_control(c1),
    .ALUresult(r1), .zero(z1), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1));

  // ---------------- dut2 and its ALU model ----------------
  logic        rst2, st2, z2, busy2, done2, pass2;
  logic [63:0] a2, b2, r2, sig2;
  logic [3:0]  c2;

  assign r2 = alu_f(a2, b2, c2);
  assign z2 = (r2 == 64'h0);

  alu_bist #(.WIDTH(64), .NUM_PATTERNS(16), .SEED_A(64'h0), .SEED_B(64'h2),
             .GOLDEN_SIG(64'h0)) dut2 (
    .clk(clk), .reset(rst2), .start(st2), .a(a2), .b(b2), .alu_control(c2),
    .ALUresult(r2), .zero(z2), .busy(busy2), .done(done2), .pass(pass2),
    .signature(sig2));

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_a"}, a1, 64'h0);
    chk({tag, "_b"}, b1, 64'h0);
    chk({tag, "_ctl"}, 64'(c1), 64'h0);
    chk({tag, "_sig"}, sig1, 64'h0);
    chk({tag, "_busy"}, 64'(busy1), 64'h0);
    chk({tag, "_done"}, 64'(done1), 64'h0);
    chk({tag, "_pass"}, 64'(pass1), 64'h0);
    chk({tag, "_state"}, 64'(dut1.state_q), 64'h0);
  endtask

  // One full NUM_PATTERNS=1 run on dut1 (20 edges). With spam set, start is
  // re-asserted on alternate cycles while busy; those edges must be ignored.
  task automatic run1(input bit inj, input bit spam, output logic [63:0] model_sig);
    logic [63:0] ea, eb, r;
    logic [3:0]  ec;
    int          k;
    inj1      = inj;
    model_sig = 64'h0;
    ea = 64'h0; eb = 64'h0; ec = 4'h0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 1) st1 = 1'b1;
      else        st1 = spam ? e[0] : 1'b0;
      tick;
      if (e[0]) begin
        k  = (e - 1) / 2;
        ea = 64'h1 << k;
        eb = 64'h2 << k;
        ec = op_f(k);
        chk($sformatf("r1_a_e%0d", e), a1, ea);
        chk($sformatf("r1_b_e%0d", e), b1, eb);
        chk($sformatf("r1_ctl_e%0d", e), 64'(c1), 64'(ec));
      end else begin
        r = alu_f(ea, eb, ec);
        if (inj && ec == OP_SUB) r[5] = ~r[5];
        model_sig = misr_f(model_sig, r);
        chk($sformatf("r1_sig_e%0d", e), sig1, model_sig);
      end
      chk($sformatf("r1_done_e%0d", e), 64'(done1), 64'(e == 20));
      chk($sformatf("r1_busy_e%0d", e), 64'(busy1), 64'(e != 20));
      if (e == 1) chk("r1_pass_clr", 64'(pass1), 64'h0);
    end
    st1 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] fs;
    logic [63:0] la, lb, msig;
    int          fall_e, ctl_bad, op_i;
    logic        done_prev;

    rst1 = 1'b1; st1 = 1'b0;
    rst2 = 1'b1; st2 = 1'b0;
    tick; tick;
    chk_zero1("rst");
    rst1 = 1'b0;
    tick;
    chk_zero1("idle");

    // First run: model must reproduce the hand-computed golden value.
    run1(1'b0, 1'b0, fs);
    chk("model_vs_gold", fs, GOLD1);
    chk("run1_sig", sig1, GOLD1);
    chk("run1_pass", 64'(pass1), 64'h1);
    tick; tick; tick;
    chk("done_hold", 64'(done1), 64'h1);
    chk("sig_hold", sig1, GOLD1);
    chk("ctl_hold", 64'(c1), 64'(op_f(9)));

    // Restart from DONE with start spammed during the run.
    run1(1'b0, 1'b1, fs);
    chk("rerun_sig", sig1, GOLD1);
    chk("rerun_pass", 64'(pass1), 64'h1);

    // Corrupted SUB result must be caught.
    run1(1'b1, 1'b0, fs);
    chk("fault_done", 64'(done1), 64'h1);
    chk("fault_pass", 64'(pass1), 64'h0);
    chk("fault_sig_ne_gold", 64'(sig1 != GOLD1), 64'h1);
    chk("fault_sig_model", sig1, fs);
    inj1 = 1'b0;

    // Reset sampled on edge 7 of a run.
    st1 = 1'b1; tick; st1 = 1'b0;
    for (int i = 2; i <= 6; i++) tick;
    chk("mid_busy", 64'(busy1), 64'h1);
    rst1 = 1'b1; tick;
    chk_zero1("midrst");
    rst1 = 1'b0; tick;
    chk("midrst_idle", 64'(dut1.state_q), 64'h0);
    run1(1'b0, 1'b0, fs);
    chk("after_rst_sig", sig1, GOLD1);
    chk("after_rst_pass", 64'(pass1), 64'h1);

    // ---------------- dut2: 16 patterns, SEED_A=0 ----------------
    rst2 = 1'b0;
    tick;
    st2 = 1'b1; tick; st2 = 1'b0;             // edge 1
    chk("s0_a", a2, 64'h1);
    chk("s0_b", b2, 64'h2);
    chk("s0_busy", 64'(busy2), 64'h1);
    ctl_bad   = (c2 === op_f(0)) ? 0 : 1;
    fall_e    = 0;
    done_prev = done2;
    for (int e = 2; e <= 400; e++) begin
      tick;
      if (busy2) begin
        op_i = (e - 1) / 32;
        if (c2 !== op_f(op_i)) ctl_bad++;
        done_prev = done2;
      end else begin
        fall_e = e;
        break;
      end
    end
    // busy spans edges 1..320: it is raised by the start edge and dropped
    // by the edge that samples the last vector.
    chk("busy_span", 64'(fall_e), 64'd320);
    chk("done_rise", 64'(done2), 64'h1);
    chk("done_prev", 64'(done_prev), 64'h0);
    chk("ctl_order_bad", 64'(ctl_bad), 64'h0);
    chk("ctl_last", 64'(c2), 64'(op_f(9)));

    la = 64'h1; lb = 64'h2; msig = 64'h0;
    for (int v = 0; v < 160; v++) begin
      msig = misr_f(msig, alu_f(la, lb, op_f(v / 16)));
      la   = lfsr_f(la);
      lb   = lfsr_f(lb);
    end
    chk("np16_sig", sig2, msig);
    chk("np16_pass", 64'(pass2), 64'(msig == 64'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
